// File: rtl/apb.sv
// Zero-wait-state APB3 slave register file fronting the I2C master core.
// Holds prescale/command/address/transmit registers; reads return core status and RX FIFO head.
module apb (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       PSELx,
    input  logic       PWRITE,
    input  logic       PENABLE,
    input  logic [6:0] PADDR,
    input  logic [7:0] PWDATA,
    input  logic [7:0] status_reg,
    input  logic [7:0] receive_reg,
    output logic       PREADY,
    output logic [7:0] PRDATA,
    output logic [7:0] transmit_reg,
    output logic [7:0] command_reg,
    output logic [7:0] prescale_reg,
    output logic [7:0] address_reg
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OFS_W  = 3;

    localparam logic [OFS_W-1:0] OFS_PRESCALE = OFS_W'(0);
    localparam logic [OFS_W-1:0] OFS_COMMAND  = OFS_W'(1);
    localparam logic [OFS_W-1:0] OFS_ADDRESS  = OFS_W'(2);
    localparam logic [OFS_W-1:0] OFS_STATUS   = OFS_W'(3);
    localparam logic [OFS_W-1:0] OFS_RECEIVE  = OFS_W'(4);
    localparam logic [OFS_W-1:0] OFS_TRANSMIT = OFS_W'(7);

    logic [OFS_W-1:0] ofs;
    logic             wr_en;
    logic             rd_sel;
    logic             unused_paddr_hi;

    // Upper address bits alias onto the same eight offsets.
    assign ofs             = PADDR[OFS_W-1:0];
    assign unused_paddr_hi = ^PADDR[6:OFS_W];

    assign wr_en  = PSELx & PENABLE & PWRITE;
    assign rd_sel = PSELx & ~PWRITE;
    assign PREADY = PSELx & PENABLE;

    // Writable control registers; reset wins over a same-cycle write.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            prescale_reg <= '0;
            command_reg  <= '0;
            address_reg  <= '0;
            transmit_reg <= '0;
        end else if (wr_en) begin
            case (ofs)
                OFS_PRESCALE: prescale_reg <= PWDATA;
                OFS_COMMAND:  command_reg  <= PWDATA;
                OFS_ADDRESS:  address_reg  <= PWDATA;
                OFS_TRANSMIT: transmit_reg <= PWDATA;
                default:      ;
            endcase
        end
    end

    // Read mux; valid in setup and access, zero when not reading.
    always_comb begin
        PRDATA = '0;
        if (rd_sel) begin
            case (ofs)
                OFS_PRESCALE: PRDATA = prescale_reg;
                OFS_COMMAND:  PRDATA = command_reg;
                OFS_ADDRESS:  PRDATA = address_reg;
                OFS_STATUS:   PRDATA = status_reg;
                OFS_RECEIVE:  PRDATA = receive_reg;
                OFS_TRANSMIT: PRDATA = transmit_reg;
                default:      PRDATA = DATA_W'(0);
            endcase
        end
    end

endmodule

// File: tb/tb_apb.sv
// Directed bench for the apb register file: reset, writes, reads, protection, aliasing.
module tb_apb;

    logic       pclk;
    logic       presetn;
    logic       psel;
    logic       pwrite;
    logic       penable;
    logic [6:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] status_in;
    logic [7:0] receive_in;
    logic       pready;
    logic [7:0] prdata;
    logic [7:0] transmit_out;
    logic [7:0] command_out;
    logic [7:0] prescale_out;
    logic [7:0] address_out;

    int tests = 0;
    int fails = 0;

    apb dut (
        .PCLK        (pclk),
        .PRESETn     (presetn),
        .PSELx       (psel),
        .PWRITE      (pwrite),
        .PENABLE     (penable),
        .PADDR       (paddr),
        .PWDATA      (pwdata),
        .status_reg  (status_in),
        .receive_reg (receive_in),
        .PREADY      (pready),
        .PRDATA      (prdata),
        .transmit_reg(transmit_out),
        .command_reg (command_out),
        .prescale_reg(prescale_out),
        .address_reg (address_out)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic bus_idle();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    endtask

    // Setup + access, returns 1 ns after the committing edge.
    task automatic do_write(input logic [6:0] a, input logic [7:0] d);
        @(posedge pclk); #1;
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        bus_idle();
    endtask

    task automatic do_read(input logic [6:0] a, output logic [7:0] d, output logic rdy);
        @(posedge pclk); #1;
        psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
        @(posedge pclk); #1;
        penable = 1'b1;
        #1;
        d = prdata; rdy = pready;
        @(posedge pclk); #1;
        bus_idle();
    endtask

    task automatic test_reset();
        logic [31:0] outs;
        do_write(7'd0, 8'h11);
        do_write(7'd1, 8'h22);
        do_write(7'd2, 8'h33);
        do_write(7'd7, 8'h44);
        tests++;
        outs = {prescale_out, command_out, address_out, transmit_out};
        if (outs !== 32'h11223344) begin
            fails++; $display("FAIL reset_prefill: got %h expected %h", outs, 32'h11223344);
        end
        @(posedge pclk); #1; presetn = 1'b0;
        @(posedge pclk); #1; presetn = 1'b1;
        tests++;
        outs = {prescale_out, command_out, address_out, transmit_out};
        if (outs !== 32'h0) begin
            fails++; $display("FAIL reset_regs: got %h expected %h", outs, 32'h0);
        end
        tests++;
        if (pready !== 1'b0) begin
            fails++; $display("FAIL reset_pready: got %b expected 0", pready);
        end
        // Reset asserted during the access cycle must win over the write.
        @(posedge pclk); #1;
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = 7'd0; pwdata = 8'h77;
        @(posedge pclk); #1;
        penable = 1'b1; presetn = 1'b0;
        @(posedge pclk); #1;
        presetn = 1'b1; bus_idle();
        tests++;
        if (prescale_out !== 8'h00) begin
            fails++; $display("FAIL reset_priority: got %h expected 00", prescale_out);
        end
    endtask

    task automatic test_write_transmit();
        @(posedge pclk); #1;
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = 7'b0001111; pwdata = 8'h55;
        #1;
        tests++;
        if (pready !== 1'b0) begin
            fails++; $display("FAIL wr_setup_pready: got %b expected 0", pready);
        end
        @(posedge pclk); #1;
        penable = 1'b1;
        #1;
        tests++;
        if (pready !== 1'b1) begin
            fails++; $display("FAIL wr_access_pready: got %b expected 1", pready);
        end
        tests++;
        if (prdata !== 8'h00) begin
            fails++; $display("FAIL wr_prdata_zero: got %h expected 00", prdata);
        end
        tests++;
        if (transmit_out !== 8'h00) begin
            fails++; $display("FAIL wr_before_edge: got %h expected 00", transmit_out);
        end
        @(posedge pclk); #1;
        bus_idle();
        tests++;
        if (transmit_out !== 8'h55) begin
            fails++; $display("FAIL wr_transmit: got %h expected 55", transmit_out);
        end
        tests++;
        if ({prescale_out, command_out, address_out} !== 24'h0) begin
            fails++; $display("FAIL wr_others: got %h expected 000000",
                              {prescale_out, command_out, address_out});
        end
    endtask

    task automatic test_read_receive();
        receive_in = 8'hAA;
        @(posedge pclk); #1;
        psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = 7'b1001100;
        #1;
        tests++;
        if (prdata !== 8'hAA) begin
            fails++; $display("FAIL rd_setup_data: got %h expected aa", prdata);
        end
        @(posedge pclk); #1;
        penable = 1'b1;
        #1;
        tests++;
        if (prdata !== 8'hAA || pready !== 1'b1) begin
            fails++; $display("FAIL rd_access: got data %h rdy %b expected aa 1", prdata, pready);
        end
        @(posedge pclk); #1;
        bus_idle();
        #1;
        tests++;
        if (prdata !== 8'h00 || pready !== 1'b0) begin
            fails++; $display("FAIL rd_idle: got data %h rdy %b expected 00 0", prdata, pready);
        end
    endtask

    task automatic test_register_sweep();
        logic [7:0] d;
        logic       r;
        logic [7:0] exp_v [3];
        exp_v[0] = 8'h12; exp_v[1] = 8'h34; exp_v[2] = 8'h56;
        for (int i = 0; i < 3; i++) do_write(7'(i), exp_v[i]);
        tests++;
        if ({prescale_out, command_out, address_out} !== 24'h123456) begin
            fails++; $display("FAIL sweep_ports: got %h expected 123456",
                              {prescale_out, command_out, address_out});
        end
        for (int i = 0; i < 3; i++) begin
            do_read(7'(i), d, r);
            tests++;
            if (d !== exp_v[i] || r !== 1'b1) begin
                fails++; $display("FAIL sweep_readback%0d: got %h rdy %b expected %h 1",
                                  i, d, r, exp_v[i]);
            end
        end
        do_read(7'd7, d, r);
        tests++;
        if (d !== 8'h55) begin
            fails++; $display("FAIL sweep_rd_transmit: got %h expected 55", d);
        end
    endtask

    task automatic test_ro_reserved();
        logic [7:0] d;
        logic       r;
        logic [31:0] outs;
        for (int i = 3; i < 7; i++) do_write(7'(i), 8'hFF);
        tests++;
        outs = {prescale_out, command_out, address_out, transmit_out};
        if (outs !== 32'h12345655) begin
            fails++; $display("FAIL ro_write_ignored: got %h expected %h", outs, 32'h12345655);
        end
        for (int i = 5; i < 7; i++) begin
            do_read(7'(i), d, r);
            tests++;
            if (d !== 8'h00) begin
                fails++; $display("FAIL rsvd_read%0d: got %h expected 00", i, d);
            end
        end
        status_in = 8'h81;
        do_read(7'd3, d, r);
        tests++;
        if (d !== 8'h81) begin
            fails++; $display("FAIL status_read: got %h expected 81", d);
        end
        status_in = 8'h3C;
        do_read(7'b0101011, d, r);
        tests++;
        if (d !== 8'h3C) begin
            fails++; $display("FAIL status_live: got %h expected 3c", d);
        end
    endtask

    task automatic test_setup_alias();
        @(posedge pclk); #1;
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = 7'd1; pwdata = 8'hEE;
        repeat (3) @(posedge pclk);
        #1;
        bus_idle();
        tests++;
        if (command_out !== 8'h34) begin
            fails++; $display("FAIL setup_only: got %h expected 34", command_out);
        end
        do_write(7'b1111000, 8'h9A);
        tests++;
        if (prescale_out !== 8'h9A) begin
            fails++; $display("FAIL alias_write: got %h expected 9a", prescale_out);
        end
    endtask

    task automatic test_back_to_back();
        // Held access rewrites the same byte, then a second transfer follows immediately.
        @(posedge pclk); #1;
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = 7'd2; pwdata = 8'hC3;
        @(posedge pclk); #1;
        penable = 1'b1;
        repeat (2) @(posedge pclk);
        #1;
        tests++;
        if (address_out !== 8'hC3) begin
            fails++; $display("FAIL held_enable: got %h expected c3", address_out);
        end
        penable = 1'b0; paddr = 7'd7; pwdata = 8'h5A;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        bus_idle();
        tests++;
        if ({address_out, transmit_out} !== 16'hC35A) begin
            fails++; $display("FAIL back_to_back: got %h expected c35a",
                              {address_out, transmit_out});
        end
    endtask

    initial begin
        presetn = 1'b0;
        status_in = 8'h00;
        receive_in = 8'h00;
        bus_idle();
        repeat (2) @(posedge pclk);
        #1;
        presetn = 1'b1;
        test_reset();
        test_write_transmit();
        test_read_receive();
        test_register_sweep();
        test_ro_reserved();
        test_setup_alias();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/apb.md
Name: apb

Overview:
- APB3-style slave register file; the CPU-side front end of the I2C master controller.
- Holds the software-writable control registers (prescale, command, slave address, transmit data) and drives them continuously to the I2C core.
- Returns the core's status and receive-FIFO data on reads.
- Zero-wait-state; 8-bit data bus.

Parameters:
- none (data width fixed at 8, address width fixed at 7)

Ports:
- PCLK  in  1  system clock; all state updates on rising edge
- PRESETn  in  1  reset, synchronous, active-low
- PSELx  in  1  slave select
- PWRITE  in  1  1 = write, 0 = read
- PENABLE  in  1  access-phase strobe
- PADDR  in  7  byte address
- PWDATA  in  8  write data
- status_reg  in  8  live status from I2C core (ack, busy, FIFO empty/full flags); read-only
- receive_reg  in  8  head of the receive FIFO from the I2C core; read-only
- PREADY  out  1  transfer complete
- PRDATA  out  8  read data
- transmit_reg  out  8  byte for transmit FIFO
- command_reg  out  8  I2C command/control byte
- prescale_reg  out  8  SCL clock prescaler
- address_reg  out  8  I2C slave address plus R/W bit

Behaviour:
- One clock (PCLK); reset is synchronous and active-low (PRESETn).
- Reset: on a rising PCLK edge with PRESETn=0, transmit_reg, command_reg, prescale_reg and address_reg all become 8'h00. Reset has priority over any write in the same cycle.
- Reset mid-transfer aborts that transfer; the write is lost.
- Address decode uses PADDR[2:0] only; PADDR[6:3] is ignored (aliased):
  - 0: prescale_reg, R/W
  - 1: command_reg, R/W
  - 2: address_reg, R/W
  - 3: status_reg, RO
  - 4: receive_reg, RO
  - 5, 6: reserved; read 8'h00, writes ignored
  - 7: transmit_reg, R/W
- Example decodes: 7'b0001111 selects transmit_reg; 7'b1001100 selects receive_reg.
- APB phases: setup = PSELx=1, PENABLE=0; access = PSELx=1, PENABLE=1.
- PREADY is combinational: PSELx & PENABLE. There are no wait states. PREADY is 0 in idle and setup.
- Write:
  - Commits on the rising edge where PSELx & PENABLE & PWRITE are all 1.
  - The target register takes PWDATA and is visible on its output port immediately after that edge (1-cycle latency from access start).
  - Writes to RO or reserved offsets are ignored.
  - If PENABLE is held high for extra cycles, the same data is rewritten each cycle; this is harmless.
- Read:
  - PRDATA is combinational: when PSELx=1 and PWRITE=0, it shows the decoded register value (status_reg / receive_reg pass straight through); otherwise 8'h00.
  - Data is valid in both setup and access phases; the master samples it in the access cycle with PREADY=1.
  - Reads have no side effects (no FIFO pop, no clear-on-read).
- A write never alters PRDATA for a concurrent read; reads and writes are mutually exclusive per transfer.
- Setup phase alone (PENABLE never asserted) causes no register change.
- Outputs transmit_reg, command_reg, prescale_reg and address_reg are direct register outputs with no combinational path from inputs.
- No error response (no PSLVERR).

Test Plan:
- Reset: PRESETn=0 for one PCLK edge after writing all registers -> all four output registers read 8'h00; PREADY=0.
- Write transmit: PADDR=7'b0001111, PWDATA=8'h55, PWRITE=1, setup then access -> PREADY=1 in access cycle; transmit_reg=8'h55 after the edge; other outputs unchanged.
- Read receive: receive_reg=8'hAA, PADDR=7'b1001100, PWRITE=0, setup then access -> PRDATA=8'hAA with PREADY=1; PRDATA=8'h00 once PSELx drops.
- Register sweep: write 8'h12/8'h34/8'h56 to offsets 0/1/2 -> prescale_reg=8'h12, command_reg=8'h34, address_reg=8'h56; read-back of each returns the same value.
- RO/reserved protection: write 8'hFF to offsets 3, 4, 5, 6 -> no output register changes; reads of 5 and 6 return 8'h00; read of 3 returns the current status_reg.
- Setup-only and aliasing: PSELx=1, PWRITE=1, PENABLE never high -> no update; write to PADDR=7'b1111000 -> prescale_reg updated.
